// File: rtl/control_unit.sv
// control_unit: multi-cycle RV32I sequencer. Steps FETCH -> DECODE -> EXECUTE -> (MEM) and
// drives the datapath strobes. It also handles a debug halt/resume handshake, emits a
// one-cycle retire pulse and holds a sticky trap indication.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset (all outputs 0 while high)
//   mem_complete              memory transaction done this cycle
//   opcode, f3                IR opcode / funct3 fields (valid from DECODE onward)
//   halt_req, resume_req      debug halt / resume requests (levels)
//   write_pc_ne/_ex, write_pc PC update strobes (PC+4 / branch-conditional / unconditional)
//   write_ir, write_rd        IR load, register-file write enable
//   write_csr                 CSR write enable
//   mem_read, mem_write       memory requests; addr_sel: 0 = ALU, 1 = PC
//   rd_sel                    00 ALU, 01 MEM, 10 CSR, 11 LINK
//   alu_insel1                00 RS, 01 PC, 10 ZR
//   alu_insel2                00 RS, 01 IM, 10 IS
//   retire, halted, trap      completion pulse, debug-halt status, sticky trap
module control_unit #(
  parameter int unsigned OPCODE_WIDTH = 7,
  parameter int unsigned F3_WIDTH     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_complete,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [F3_WIDTH-1:0]     f3,
  input  logic                    halt_req,
  input  logic                    resume_req,
  output logic                    write_pc_ne,
  output logic                    write_pc_ex,
  output logic                    write_pc,
  output logic                    write_ir,
  output logic                    write_rd,
  output logic                    write_csr,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    addr_sel,
  output logic [1:0]              rd_sel,
  output logic [1:0]              alu_insel1,
  output logic [1:0]              alu_insel2,
  output logic                    retire,
  output logic                    halted,
  output logic                    trap
);

  localparam logic [OPCODE_WIDTH-1:0] OpOp     = OPCODE_WIDTH'(7'b0110011);
  localparam logic [OPCODE_WIDTH-1:0] OpOpImm  = OPCODE_WIDTH'(7'b0010011);
  localparam logic [OPCODE_WIDTH-1:0] OpLui    = OPCODE_WIDTH'(7'b0110111);
  localparam logic [OPCODE_WIDTH-1:0] OpAuipc  = OPCODE_WIDTH'(7'b0010111);
  localparam logic [OPCODE_WIDTH-1:0] OpJal    = OPCODE_WIDTH'(7'b1101111);
  localparam logic [OPCODE_WIDTH-1:0] OpJalr   = OPCODE_WIDTH'(7'b1100111);
  localparam logic [OPCODE_WIDTH-1:0] OpBranch = OPCODE_WIDTH'(7'b1100011);
  localparam logic [OPCODE_WIDTH-1:0] OpLoad   = OPCODE_WIDTH'(7'b0000011);
  localparam logic [OPCODE_WIDTH-1:0] OpStore  = OPCODE_WIDTH'(7'b0100011);
  localparam logic [OPCODE_WIDTH-1:0] OpFence  = OPCODE_WIDTH'(7'b0001111);
  localparam logic [OPCODE_WIDTH-1:0] OpSystem = OPCODE_WIDTH'(7'b1110011);

  localparam logic [1:0] RdAlu  = 2'b00;
  localparam logic [1:0] RdMem  = 2'b01;
  localparam logic [1:0] RdCsr  = 2'b10;
  localparam logic [1:0] RdLink = 2'b11;
  localparam logic [1:0] In1Rs  = 2'b00;
  localparam logic [1:0] In1Pc  = 2'b01;
  localparam logic [1:0] In1Zr  = 2'b10;
  localparam logic [1:0] In2Rs  = 2'b00;
  localparam logic [1:0] In2Im  = 2'b01;
  localparam logic [1:0] In2Is  = 2'b10;

  typedef enum logic [2:0] {StFetch, StDecode, StExecute, StMem, StHalt, StTrap} state_e;

  state_e state_q, state_d;
  // Set once a fetch is committed (request outstanding or just resumed): halt_req is then
  // ignored until the instruction finishes, so a fetch is never abandoned.
  logic   fetch_go_q, fetch_go_d;
  logic   opcode_legal, is_load, mem_phase;
  logic   shift_f3, load_f3_ok, store_f3_ok, branch_f3_ok, sys_f3_ok, jalr_f3_ok;

  assign opcode_legal = opcode inside {OpOp, OpOpImm, OpLui, OpAuipc, OpJal, OpJalr,
                                       OpBranch, OpLoad, OpStore, OpFence, OpSystem};
  assign is_load      = (opcode == OpLoad);
  assign shift_f3     = (f3 == F3_WIDTH'(1)) || (f3 == F3_WIDTH'(5));
  assign load_f3_ok   = (f3 == F3_WIDTH'(0)) || (f3 == F3_WIDTH'(1)) || (f3 == F3_WIDTH'(2)) ||
                        (f3 == F3_WIDTH'(4)) || (f3 == F3_WIDTH'(5));
  assign store_f3_ok  = (f3 <= F3_WIDTH'(2));
  assign branch_f3_ok = !((f3 == F3_WIDTH'(2)) || (f3 == F3_WIDTH'(3)));
  assign sys_f3_ok    = !((f3 == F3_WIDTH'(0)) || (f3 == F3_WIDTH'(4)));
  assign jalr_f3_ok   = (f3 == F3_WIDTH'(0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFetch;
      fetch_go_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_go_q <= fetch_go_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_go_d  = 1'b0;
    mem_phase   = 1'b0;
    write_pc_ne = 1'b0;
    write_pc_ex = 1'b0;
    write_pc    = 1'b0;
    write_ir    = 1'b0;
    write_rd    = 1'b0;
    write_csr   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    addr_sel    = 1'b0;
    rd_sel      = RdAlu;
    alu_insel1  = In1Rs;
    alu_insel2  = In2Rs;
    retire      = 1'b0;
    halted      = 1'b0;
    trap        = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (halt_req && !fetch_go_q) begin
          state_d = StHalt;
        end else begin
          mem_read = 1'b1;
          addr_sel = 1'b1;
          if (mem_complete) begin
            write_ir = 1'b1;
            state_d  = StDecode;
          end else begin
            fetch_go_d = 1'b1;
          end
        end
      end
      StDecode: state_d = opcode_legal ? StExecute : StTrap;
      StExecute: begin
        state_d = StFetch;
        unique case (opcode)
          OpOp, OpOpImm, OpLui, OpAuipc: begin
            alu_insel1  = (opcode == OpLui) ? In1Zr : (opcode == OpAuipc) ? In1Pc : In1Rs;
            alu_insel2  = (opcode == OpOp) ? In2Rs :
                          (opcode == OpOpImm && shift_f3) ? In2Is : In2Im;
            write_rd    = 1'b1;
            write_pc_ne = 1'b1;
            retire      = 1'b1;
          end
          OpJal, OpJalr: begin
            if (opcode == OpJalr && !jalr_f3_ok) begin
              state_d = StTrap;
            end else begin
              alu_insel1 = (opcode == OpJal) ? In1Pc : In1Rs;
              alu_insel2 = In2Im;
              write_pc   = 1'b1;
              write_rd   = 1'b1;
              rd_sel     = RdLink;
              retire     = 1'b1;
            end
          end
          OpBranch: begin
            if (!branch_f3_ok) begin
              state_d = StTrap;
            end else begin
              alu_insel1  = In1Pc;
              alu_insel2  = In2Im;
              write_pc_ex = 1'b1;
              retire      = 1'b1;
            end
          end
          OpLoad:  if (load_f3_ok)  mem_phase = 1'b1; else state_d = StTrap;
          OpStore: if (store_f3_ok) mem_phase = 1'b1; else state_d = StTrap;
          OpFence: begin
            write_pc_ne = 1'b1;
            retire      = 1'b1;
          end
          OpSystem: begin
            if (!sys_f3_ok) begin
              state_d = StTrap;
            end else begin
              write_csr   = 1'b1;
              write_rd    = 1'b1;
              rd_sel      = RdCsr;
              alu_insel2  = In2Im;
              write_pc_ne = 1'b1;
              retire      = 1'b1;
            end
          end
          default: state_d = StTrap;
        endcase
      end
      StMem: mem_phase = 1'b1;
      StHalt: begin
        halted = 1'b1;
        if (resume_req) begin
          state_d    = StFetch;
          fetch_go_d = 1'b1;
        end
      end
      StTrap:  trap = 1'b1;
      default: state_d = StFetch;
    endcase

    // Shared by the EXECUTE cycle of a load/store and every MEM cycle: a completion seen in
    // EXECUTE finishes the access there and skips MEM entirely.
    if (mem_phase) begin
      alu_insel1 = In1Rs;
      alu_insel2 = In2Im;
      mem_read   = is_load;
      mem_write  = !is_load;
      state_d    = mem_complete ? StFetch : StMem;
      if (mem_complete) begin
        write_pc_ne = 1'b1;
        retire      = 1'b1;
        write_rd    = is_load;
        rd_sel      = is_load ? RdMem : RdAlu;
      end
    end

    if (rst) begin
      write_pc_ne = 1'b0;
      write_pc_ex = 1'b0;
      write_pc    = 1'b0;
      write_ir    = 1'b0;
      write_rd    = 1'b0;
      write_csr   = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      addr_sel    = 1'b0;
      rd_sel      = 2'b00;
      alu_insel1  = 2'b00;
      alu_insel2  = 2'b00;
      retire      = 1'b0;
      halted      = 1'b0;
      trap        = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  localparam logic [6:0] OP_OP = 7'b0110011, OP_IMM = 7'b0010011, OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
  localparam logic [6:0] OP_FENCE = 7'b0001111, OP_SYS = 7'b1110011;

  typedef struct packed {
    logic       pc_ne, pc_ex, pc, ir, rd, csr, mrd, mwr, asel;
    logic [1:0] rsel, in1, in2;
    logic       ret, hlt, trp;
  } ctl_t;

  logic       clk, rst, mem_complete, halt_req, resume_req;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic       write_pc_ne, write_pc_ex, write_pc, write_ir, write_rd, write_csr;
  logic       mem_read, mem_write, addr_sel, retire, halted, trap;
  logic [1:0] rd_sel, alu_insel1, alu_insel2;
  ctl_t       obs;
  int unsigned total, bad;

  assign obs = {write_pc_ne, write_pc_ex, write_pc, write_ir, write_rd, write_csr, mem_read,
                mem_write, addr_sel, rd_sel, alu_insel1, alu_insel2, retire, halted, trap};

  control_unit #(.OPCODE_WIDTH(7), .F3_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .mem_complete(mem_complete), .opcode(opcode), .f3(f3),
    .halt_req(halt_req), .resume_req(resume_req), .write_pc_ne(write_pc_ne),
    .write_pc_ex(write_pc_ex), .write_pc(write_pc), .write_ir(write_ir), .write_rd(write_rd),
    .write_csr(write_csr), .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel),
    .rd_sel(rd_sel), .alu_insel1(alu_insel1), .alu_insel2(alu_insel2), .retire(retire),
    .halted(halted), .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=timeout required=finish");
    $fatal(1);
  end

  // ---------------- reference model (instruction-level rules) ----------------
  function automatic bit op_legal(input logic [6:0] op);
    return op inside {OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST,
                      OP_FENCE, OP_SYS};
  endfunction

  function automatic bit f3_legal(input logic [6:0] op, input logic [2:0] f);
    case (op)
      OP_JALR: return f == 3'd0;
      OP_BR:   return !(f == 3'd2 || f == 3'd3);
      OP_LD:   return f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      OP_ST:   return f <= 3'd2;
      OP_SYS:  return !(f == 3'd0 || f == 3'd4);
      default: return 1'b1;
    endcase
  endfunction

  function automatic ctl_t fetch_exp(input bit done);
    ctl_t c = '0;
    c.mrd = 1'b1; c.asel = 1'b1; c.ir = done;
    return c;
  endfunction

  function automatic ctl_t mem_exp(input bit load, input bit done);
    ctl_t c = '0;
    c.in2 = 2'b01; c.mrd = load; c.mwr = !load;
    if (done) begin
      c.pc_ne = 1'b1; c.ret = 1'b1;
      if (load) begin c.rd = 1'b1; c.rsel = 2'b01; end
    end
    return c;
  endfunction

  // EXECUTE-cycle bundle for legal non-memory instructions.
  function automatic ctl_t exec_exp(input logic [6:0] op, input logic [2:0] f);
    ctl_t c = '0;
    case (op)
      OP_OP, OP_IMM, OP_LUI, OP_AUIPC: begin
        c.rd = 1'b1; c.pc_ne = 1'b1; c.ret = 1'b1; c.in2 = 2'b01;
        if (op == OP_OP) c.in2 = 2'b00;
        if (op == OP_IMM && (f == 3'd1 || f == 3'd5)) c.in2 = 2'b10;
        if (op == OP_LUI) c.in1 = 2'b10;
        if (op == OP_AUIPC) c.in1 = 2'b01;
      end
      OP_JAL, OP_JALR: begin
        c.pc = 1'b1; c.rd = 1'b1; c.rsel = 2'b11; c.ret = 1'b1; c.in2 = 2'b01;
        c.in1 = (op == OP_JAL) ? 2'b01 : 2'b00;
      end
      OP_BR:    begin c.in1 = 2'b01; c.in2 = 2'b01; c.pc_ex = 1'b1; c.ret = 1'b1; end
      OP_FENCE: begin c.pc_ne = 1'b1; c.ret = 1'b1; end
      OP_SYS: begin
        c.csr = 1'b1; c.rd = 1'b1; c.rsel = 2'b10; c.in2 = 2'b01; c.pc_ne = 1'b1;
        c.ret = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic ctl_t flag_exp(input bit h, input bit t);
    ctl_t c = '0;
    c.hlt = h; c.trp = t;
    return c;
  endfunction

  function automatic logic [6:0] pick_op(input int unsigned idx);
    case (idx)
      0: return OP_OP;    1: return OP_IMM;  2: return OP_LUI;   3: return OP_AUIPC;
      4: return OP_JAL;   5: return OP_JALR; 6: return OP_BR;    7: return OP_LD;
      8: return OP_ST;    9: return OP_FENCE; 10: return OP_SYS;
      default: return 7'($urandom);
    endcase
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_complete = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_complete = 1'($urandom); halt_req = 1'($urandom); resume_req = 1'($urandom);
      opcode = 7'($urandom); f3 = 3'($urandom);
      @(negedge clk);
      total++;
      if (obs !== ctl_t'('0)) begin
        bad++; $display("FAIL reset_outputs c%0d got=%h exp=%h", i, obs, ctl_t'('0));
      end
      tick();
    end
    rst = 1'b0; mem_complete = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== fetch_exp(1'b0)) begin
      bad++; $display("FAIL reset_first_fetch got=%h exp=%h", obs, fetch_exp(1'b0));
    end
    tick();
  endtask

  task automatic test_fetch_wait();
    do_reset();
    opcode = OP_OP; f3 = 3'd0;
    for (int i = 0; i < 3; i++) begin
      mem_complete = (i == 2);
      @(negedge clk);
      total++;
      if (obs !== fetch_exp(i == 2)) begin
        bad++; $display("FAIL fetch_wait c%0d got=%h exp=%h", i, obs, fetch_exp(i == 2));
      end
      tick();
    end
    mem_complete = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== ctl_t'('0)) begin
      bad++; $display("FAIL fetch_wait_decode got=%h exp=%h", obs, ctl_t'('0));
    end
    tick();
  endtask

  task automatic test_add();
    do_reset();
    opcode = OP_OP; f3 = 3'd0; mem_complete = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== fetch_exp(1'b1)) begin
      bad++; $display("FAIL add_fetch got=%h exp=%h", obs, fetch_exp(1'b1));
    end
    tick();
    @(negedge clk);
    total++;
    if (obs !== ctl_t'('0)) begin
      bad++; $display("FAIL add_decode got=%h exp=%h", obs, ctl_t'('0));
    end
    tick();
    mem_complete = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== exec_exp(OP_OP, 3'd0)) begin
      bad++; $display("FAIL add_exec got=%h exp=%h", obs, exec_exp(OP_OP, 3'd0));
    end
    tick();
    @(negedge clk);
    total++;
    if (obs !== fetch_exp(1'b0)) begin
      bad++; $display("FAIL add_next_fetch got=%h exp=%h", obs, fetch_exp(1'b0));
    end
    tick();
  endtask

  task automatic test_lw();
    do_reset();
    opcode = OP_LD; f3 = 3'd2; mem_complete = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_complete = (i == 2);
      @(negedge clk);
      total++;
      if (obs !== mem_exp(1'b1, i == 2)) begin
        bad++; $display("FAIL lw_mem c%0d got=%h exp=%h", i, obs, mem_exp(1'b1, i == 2));
      end
      tick();
    end
  endtask

  task automatic test_jal_beq_trap();
    logic [6:0] ops [3];
    logic [2:0] fs [3];
    ctl_t e;
    ops = '{OP_JAL, OP_BR, OP_BR};
    fs  = '{3'd0, 3'd0, 3'd2};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      opcode = ops[k]; f3 = fs[k]; mem_complete = 1'b1;
      tick();
      mem_complete = 1'b0;
      tick();
      e = f3_legal(ops[k], fs[k]) ? exec_exp(ops[k], fs[k]) : ctl_t'('0);
      @(negedge clk);
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL jal_beq_exec k%0d got=%h exp=%h", k, obs, e);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      mem_complete = 1'($urandom); halt_req = 1'($urandom); resume_req = 1'($urandom);
      @(negedge clk);
      total++;
      if (obs !== flag_exp(1'b0, 1'b1)) begin
        bad++; $display("FAIL trap_sticky c%0d got=%h exp=%h", i, obs, flag_exp(1'b0, 1'b1));
      end
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== ctl_t'('0)) begin
      bad++; $display("FAIL trap_reset got=%h exp=%h", obs, ctl_t'('0));
    end
    tick();
    rst = 1'b0; mem_complete = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== fetch_exp(1'b0)) begin
      bad++; $display("FAIL trap_exit_fetch got=%h exp=%h", obs, fetch_exp(1'b0));
    end
    tick();
  endtask

  task automatic test_halt();
    ctl_t e [8];
    do_reset();
    opcode = OP_ST; f3 = 3'd2; mem_complete = 1'b1;
    tick();
    tick();
    mem_complete = 1'b0;
    tick();
    // Cycle-by-cycle from the first MEM cycle; inputs applied below per index.
    e = '{mem_exp(1'b0, 1'b0), mem_exp(1'b0, 1'b1), ctl_t'('0), flag_exp(1'b1, 1'b0),
          flag_exp(1'b1, 1'b0), fetch_exp(1'b0), fetch_exp(1'b0), fetch_exp(1'b1)};
    for (int i = 0; i < 8; i++) begin
      halt_req     = (i < 7);
      mem_complete = (i == 1 || i == 7);
      resume_req   = (i == 4);
      @(negedge clk);
      total++;
      if (obs !== e[i]) begin
        bad++; $display("FAIL halt_seq c%0d got=%h exp=%h", i, obs, e[i]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    opcode = OP_LD; f3 = 3'd0; mem_complete = 1'b1;
    tick();
    tick();
    mem_complete = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== ctl_t'('0)) begin
      bad++; $display("FAIL reset_mid_mem got=%h exp=%h", obs, ctl_t'('0));
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (obs !== fetch_exp(1'b0)) begin
      bad++; $display("FAIL reset_mid_mem_fetch got=%h exp=%h", obs, fetch_exp(1'b0));
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 80; n++) begin
      logic [6:0]  op;
      logic [2:0]  fn;
      int unsigned fw, mw;
      bit          dead;
      op = pick_op($urandom_range(0, 11));
      fn = 3'($urandom);
      opcode = op; f3 = fn;
      fw = $urandom_range(0, 2);
      for (int w = 0; w <= int'(fw); w++) begin
        mem_complete = (w == int'(fw));
        @(negedge clk);
        total++;
        if (obs !== fetch_exp(w == int'(fw))) begin
          bad++; $display("FAIL rnd_fetch n%0d got=%h exp=%h", n, obs, fetch_exp(w == int'(fw)));
        end
        tick();
      end
      mem_complete = 1'($urandom);
      @(negedge clk);
      total++;
      if (obs !== ctl_t'('0)) begin
        bad++; $display("FAIL rnd_decode n%0d op=%b got=%h exp=%h", n, op, obs, ctl_t'('0));
      end
      tick();
      dead = !op_legal(op);
      if (!dead && !f3_legal(op, fn)) begin
        mem_complete = 1'($urandom);
        @(negedge clk);
        total++;
        if (obs !== ctl_t'('0)) begin
          bad++; $display("FAIL rnd_exec_bad_f3 n%0d op=%b f3=%0d got=%h exp=%h", n, op, fn,
                          obs, ctl_t'('0));
        end
        tick();
        dead = 1'b1;
      end else if (!dead && (op == OP_LD || op == OP_ST)) begin
        mw = $urandom_range(0, 2);
        for (int j = 0; j <= int'(mw); j++) begin
          mem_complete = (j == int'(mw));
          @(negedge clk);
          total++;
          if (obs !== mem_exp(op == OP_LD, j == int'(mw))) begin
            bad++; $display("FAIL rnd_mem n%0d c%0d got=%h exp=%h", n, j, obs,
                            mem_exp(op == OP_LD, j == int'(mw)));
          end
          tick();
        end
      end else if (!dead) begin
        mem_complete = 1'($urandom);
        @(negedge clk);
        total++;
        if (obs !== exec_exp(op, fn)) begin
          bad++; $display("FAIL rnd_exec n%0d op=%b f3=%0d got=%h exp=%h", n, op, fn, obs,
                          exec_exp(op, fn));
        end
        tick();
      end
      if (dead) begin
        mem_complete = 1'($urandom);
        @(negedge clk);
        total++;
        if (obs !== flag_exp(1'b0, 1'b1)) begin
          bad++; $display("FAIL rnd_trap n%0d got=%h exp=%h", n, obs, flag_exp(1'b0, 1'b1));
        end
        tick();
        do_reset();
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; mem_complete = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
    opcode = '0; f3 = '0;
    test_reset();
    test_fetch_wait();
    test_add();
    test_lw();
    test_jal_beq_trap();
    test_halt();
    test_reset_mid_mem();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multi-cycle FSM that drives the core's control-signal bundle: it consumes `mem_complete`, `opcode` and `f3`, and produces every `write_*`, `mem_*` and `*_sel` strobe.
It sits directly upstream of the datapath, which consumes these strobes. It sequences FETCH → DECODE → EXECUTE → (MEM) per RV32I instruction.
It also adds a debug halt/resume handshake, a retire pulse and a sticky trap indication.

Parameters:
- OPCODE_WIDTH, 7, opcode field width (= ISA opcode width).
- F3_WIDTH, 3, funct3 field width (= ISA funct3 width).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_complete  in  1  memory transaction done this cycle.
- opcode  in  OPCODE_WIDTH  opcode field of the IR; valid from DECODE onward.
- f3  in  F3_WIDTH  funct3 field of the IR.
- halt_req  in  1  debug halt request (level).
- resume_req  in  1  debug resume request (level).
- write_pc_ne  out  1  PC <= PC+4.
- write_pc_ex  out  1  PC <= ALU result if the datapath branch comparator (funct3-selected) is true, else PC+4.
- write_pc  out  1  PC <= ALU result, unconditional.
- write_ir  out  1  IR <= memory read data.
- write_rd  out  1  register file write enable.
- write_csr  out  1  CSR write enable.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- addr_sel  out  1  0 = ALU, 1 = PC.
- rd_sel  out  2  00 = ALU, 01 = MEM, 10 = CSR, 11 = LINK (PC+4).
- alu_insel1  out  2  00 = RS, 01 = PC, 10 = ZR.
- alu_insel2  out  2  00 = RS, 01 = IM, 10 = IS.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  core is in the debug HALT state.
- trap  out  1  sticky; an illegal instruction or ECALL/EBREAK was reached.

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEM, HALT, TRAP. Reset state is FETCH.
- While `rst` is high, every output is 0. This includes `rd_sel`, `alu_insel1` and `alu_insel2` (= 00) and `addr_sel` (= 0).
- Outputs are combinational from the state, the registered opcode/f3 inputs and `mem_complete`. Any output not listed for a state is 0 in that state.

FETCH:
- If `halt_req` is high on entry, go to HALT; no memory request is issued.
- Otherwise assert `mem_read` with `addr_sel` = 1.
- Hold both until `mem_complete`. In the `mem_complete` cycle assert `write_ir`; next state is DECODE.
- Zero-wait memory (`mem_complete` in the first cycle) is legal: FETCH lasts 1 cycle.

DECODE:
- Lasts 1 cycle. Legal opcode → EXECUTE; otherwise → TRAP.

EXECUTE (1 cycle unless noted):
- OP: `alu_insel1`/`alu_insel2` = RS/RS, `write_rd`, `rd_sel` = ALU, `write_pc_ne`, `retire` → FETCH.
- OP-IMM: RS/IM, or RS/IS when f3 = 001 or 101. Otherwise as OP.
- LUI: ZR/IM. AUIPC: PC/IM. Both otherwise as OP.
- JAL: PC/IM, `write_pc`, `write_rd`, `rd_sel` = LINK, `retire`.
- JALR: RS/IM, otherwise as JAL. f3 ≠ 000 → TRAP.
- BRANCH: PC/IM, `write_pc_ex`, `retire`. f3 = 010 or 011 → TRAP.
- LOAD: RS/IM, `addr_sel` = 0, `mem_read` → MEM. f3 ∈ {000, 001, 010, 100, 101} is legal; any other f3 → TRAP.
- STORE: RS/IM, `addr_sel` = 0, `mem_write` → MEM. f3 > 010 → TRAP.
- MISC-MEM (FENCE): `write_pc_ne`, `retire`.
- SYSTEM, f3 ∈ {001, 010, 011, 101, 110, 111}: `write_csr`, `write_rd`, `rd_sel` = CSR, `alu_insel1` = RS, `alu_insel2` = IM, `write_pc_ne`, `retire`.
- SYSTEM, f3 = 000 or 100 → TRAP.
- If `mem_complete` is already high in the EXECUTE cycle of a LOAD/STORE, the MEM completion actions happen in that cycle and the next state is FETCH.

MEM:
- Hold `mem_read`/`mem_write`, `addr_sel` = 0 and the ALU selects unchanged until `mem_complete`.
- LOAD completion: `write_rd`, `rd_sel` = MEM, `write_pc_ne`, `retire`.
- STORE completion: `write_pc_ne`, `retire`.
- Next state is FETCH.
- A request is never dropped before `mem_complete`; `halt_req` is ignored here.

HALT:
- `halted` = 1, all strobes 0.
- Stay while `resume_req` is low. When `resume_req` is high → FETCH, even if `halt_req` is still high; that FETCH then starts a fetch.
- Halt is taken only at instruction boundaries (FETCH entry).

TRAP:
- `trap` = 1, all other outputs 0. Exit only through `rst`.

Exclusivity and reset:
- At most one of `write_pc`, `write_pc_ne`, `write_pc_ex` is high in any cycle. `mem_read` and `mem_write` are never both high.
- Reset mid-MEM or mid-FETCH returns to FETCH next cycle; the abandoned request drops immediately.

Test Plan:
1. Reset, then fetch with `mem_complete` on the 3rd cycle → `mem_read` = 1 and `addr_sel` = 1 for 3 cycles, `write_ir` only in cycle 3, DECODE next.
2. ADD (opcode 0110011), zero-wait memory → FETCH, DECODE, EXECUTE = 3 cycles. In EXECUTE: `write_rd` = 1, `rd_sel` = 00, `write_pc_ne` = 1, `retire` = 1.
3. LW (0000011, f3 = 010), `mem_complete` 2 cycles after EXECUTE → `mem_read` held with `addr_sel` = 0. In the complete cycle: `rd_sel` = 01, `write_rd`, `retire`.
4. JAL (1101111) → `write_pc` = 1, `rd_sel` = 11, `alu_insel1` = 01, `alu_insel2` = 01. BEQ → `write_pc_ex` = 1 only. BRANCH with f3 = 010 → `trap` = 1 and stays high until `rst`.
5. `halt_req` high during a SW in MEM → SW completes (`retire`), then HALT with no `mem_read`. `resume_req` pulse → FETCH next cycle, `halted` = 0.
6. `rst` asserted mid-MEM → all outputs 0 during reset. First cycle after reset is FETCH with `mem_read` = 1.
